// File: rtl/edge_event_arbiter_if.sv
// ============================================================================
//  Module   : edge_event_arbiter_if
//  Purpose  : Groups the arbiter's channel inputs, configuration masks,
//             overflow status and the valid/ready event port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface edge_event_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) ();

  logic [NUM_CH-1:0] signal_in;
  logic [NUM_CH-1:0] rise_en;
  logic [NUM_CH-1:0] fall_en;
  logic              evt_valid;
  logic              evt_ready;
  logic [ID_W-1:0]   evt_ch;
  logic              evt_rise;
  logic [NUM_CH-1:0] overflow;
  logic              ovf_clear;

  // Arbiter side: produces events and overflow status.
  modport master (
    input  signal_in,
    input  rise_en,
    input  fall_en,
    input  evt_ready,
    input  ovf_clear,
    output evt_valid,
    output evt_ch,
    output evt_rise,
    output overflow
  );

  // Environment / consumer side.
  modport slave (
    output signal_in,
    output rise_en,
    output fall_en,
    output evt_ready,
    output ovf_clear,
    input  evt_valid,
    input  evt_ch,
    input  evt_rise,
    input  overflow
  );

endinterface

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// ============================================================================
//  Module   : edge_event_arbiter
//  Purpose  : Detects rising/falling edges on NUM_CH synchronous inputs,
//             keeps one pending event per channel and serialises them onto
//             a single valid/ready port with round-robin fairness. Edges
//             dropped because a slot is occupied set sticky overflow bits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  edge_event_arbiter_if.master  bus
);

  localparam logic [ID_W-1:0]   c_LAST_CH = ID_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] c_ONE     = NUM_CH'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Registered state
  state_t            r_state;
  logic [NUM_CH-1:0] r_prev;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_ptype;
  logic [NUM_CH-1:0] r_overflow;
  logic              r_evt_valid;
  logic [ID_W-1:0]   r_evt_ch;
  logic              r_evt_rise;
  logic [ID_W-1:0]   r_rr_ptr;

  // Combinational
  state_t            w_state_next;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_qual;
  logic [NUM_CH-1:0] w_drop;
  logic [NUM_CH-1:0] w_drain;
  logic [NUM_CH-1:0] w_pending_next;
  logic [NUM_CH-1:0] w_ptype_next;
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic              w_load;
  logic              w_release;

  // Channel index reached by stepping 'off' positions past 'base', modulo NUM_CH.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return sum[ID_W-1:0];
  endfunction

  // Per-channel edge qualification and next-slot computation. A slot that is
  // drained this cycle is free to accept a new edge, so no overflow occurs.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_rise[i]         = bus.signal_in[i] & ~r_prev[i];
    assign w_fall[i]         = ~bus.signal_in[i] & r_prev[i];
    assign w_qual[i]         = (w_rise[i] & bus.rise_en[i]) | (w_fall[i] & bus.fall_en[i]);
    assign w_drop[i]         = w_qual[i] & r_pending[i] & ~w_drain[i];
    assign w_pending_next[i] = w_qual[i] | (r_pending[i] & ~w_drain[i]);
    assign w_ptype_next[i]   = (w_qual[i] & ~w_drop[i]) ? w_rise[i] : r_ptype[i];
  end

  // Round-robin search: walk offsets from NUM_CH down to 1 so the closest
  // pending channel after the last grant overwrites farther ones.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (r_pending[rr_index(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_index(r_rr_ptr, k);
      end
    end
  end

  // Next-state logic: decide when to load a new winner or retire the offer.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_load       = 1'b1;
          w_state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (r_evt_valid && bus.evt_ready) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_release    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_drain = w_load ? (c_ONE << w_winner) : '0;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Edge history and pending slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_ptype   <= '0;
    end else begin
      r_prev    <= bus.signal_in;
      r_pending <= w_pending_next;
      r_ptype   <= w_ptype_next;
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_overflow <= '0;
    else     r_overflow <= (bus.ovf_clear ? '0 : r_overflow) | w_drop;
  end

  // Registered event port and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_rise  <= 1'b0;
      r_rr_ptr    <= c_LAST_CH;
    end else if (w_load) begin
      r_evt_valid <= 1'b1;
      r_evt_ch    <= w_winner;
      r_evt_rise  <= r_ptype[w_winner];
      r_rr_ptr    <= w_winner;
    end else if (w_release) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_ch    = r_evt_ch;
  assign bus.evt_rise  = r_evt_rise;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire
